// File: rtl/io_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus strobe levels, register
// offsets, STATUS/CTRL bit positions and TX FSM state encodings.
package io_uart_tx_pkg;

    localparam logic        RamEnable = 1'b1;
    localparam logic        RamWrite  = 1'b1;
    localparam logic [31:0] Zero      = 32'h0000_0000;

    typedef enum logic [1:0] {
        RegTxData  = 2'd0,
        RegStatus  = 2'd1,
        RegBaudDiv = 2'd2,
        RegCtrl    = 2'd3
    } reg_addr_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned StatFullBit  = 0;
    localparam int unsigned StatEmptyBit = 1;
    localparam int unsigned StatBusyBit  = 2;
    localparam int unsigned StatOvfBit   = 3;
    localparam int unsigned StatCountLsb = 8;

    localparam int unsigned CtrlTxEnBit   = 0;
    localparam int unsigned CtrlFifoClrBit = 1;
    localparam int unsigned CtrlIrqEnBit  = 2;
    localparam int unsigned CtrlOvfClrBit = 3;

    // A divisor of 0 would never produce a bit tick, so it is stored as 1.
    function automatic logic [15:0] sanitize_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO; pointers carry an extra wrap bit so full and empty are
// distinguished by the pointer difference.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clr_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         dout_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW + 1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    // Clear wins over any same-cycle push or pop.
    assign do_push = push_i & ~full_o & ~clr_i;
    assign do_pop  = pop_i & ~empty_o & ~clr_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, address decode, TX FIFO and the
// bit-serialising FSM with its programmable baud counter.
module io_uart_tx
    import io_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ioCe,
    input  logic        ioWe,
    input  logic [31:0] ioAddr,
    input  logic [31:0] ioWtData,
    output logic [31:0] ioRdData,
    output logic        txd,
    output logic        txIrq
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    reg_addr_e        reg_sel;
    logic             wr_en, ctrl_wr, fifo_push, fifo_clr, ovf_clr;
    logic             fifo_full, fifo_empty, fifo_pop, can_pop;
    logic [CntW-1:0]  fifo_count;
    logic [7:0]       fifo_dout;

    logic [15:0]      baud_div_q, baud_div_d;
    logic             tx_en_q, tx_en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;

    tx_state_e        state_q, state_d;
    logic [15:0]      baud_cnt_q, baud_cnt_d, bit_lim_q, bit_lim_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             bit_tick, tx_busy;

    logic             unused_io;
    assign unused_io = ^{ioAddr[31:4], ioAddr[1:0], ioWtData[31:16]};

    assign reg_sel   = reg_addr_e'(ioAddr[3:2]);
    assign wr_en     = (ioCe == RamEnable) && (ioWe == RamWrite);
    assign ctrl_wr   = wr_en && (reg_sel == RegCtrl);
    assign fifo_push = wr_en && (reg_sel == RegTxData);
    assign fifo_clr  = ctrl_wr && ioWtData[CtrlFifoClrBit];
    assign ovf_clr   = ctrl_wr && ioWtData[CtrlOvfClrBit];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clr_i   (fifo_clr),
        .din_i   (ioWtData[7:0]),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .dout_o  (fifo_dout)
    );

    always_comb begin
        baud_div_d = baud_div_q;
        tx_en_d    = tx_en_q;
        irq_en_d   = irq_en_q;
        ovf_d      = ovf_q | (fifo_push & fifo_full);
        if (ovf_clr) ovf_d = 1'b0;
        if (wr_en && reg_sel == RegBaudDiv) baud_div_d = sanitize_div(ioWtData[15:0]);
        if (ctrl_wr) begin
            tx_en_d  = ioWtData[CtrlTxEnBit];
            irq_en_d = ioWtData[CtrlIrqEnBit];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_div_q <= DEFAULT_DIV;
            tx_en_q    <= 1'b0;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            baud_div_q <= baud_div_d;
            tx_en_q    <= tx_en_d;
            irq_en_q   <= irq_en_d;
            ovf_q      <= ovf_d;
        end
    end

    // A byte being cleared this cycle must not be launched.
    assign can_pop  = tx_en_q && !fifo_empty && !fifo_clr;
    assign bit_tick = (state_q != StIdle) && (baud_cnt_q == bit_lim_q - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (can_pop) state_d = StStart;
            StStart: if (bit_tick) state_d = StData;
            StData:  if (bit_tick && bit_idx_q == 3'd7) state_d = StStop;
            StStop:  if (bit_tick) state_d = can_pop ? StStart : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fifo_pop = can_pop && ((state_q == StIdle) || (state_q == StStop && bit_tick));
        tx_busy  = (state_q != StIdle);
    end

    always_comb begin
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        txd_d      = txd_q;
        bit_lim_d  = bit_lim_q;
        baud_cnt_d = (state_q == StIdle || bit_tick) ? 16'd0 : baud_cnt_q + 16'd1;
        if (fifo_pop) begin
            shift_d   = fifo_dout;
            bit_idx_d = 3'd0;
            txd_d     = 1'b0;
            bit_lim_d = baud_div_q;
        end else if (bit_tick) begin
            // New divisor is picked up only at a bit boundary.
            bit_lim_d = baud_div_q;
            case (state_q)
                StStart: begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = 3'd0;
                end
                StData: begin
                    if (bit_idx_q == 3'd7) begin
                        txd_d = 1'b1;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                default: txd_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            txd_q      <= 1'b1;
            baud_cnt_q <= 16'd0;
            bit_lim_q  <= DEFAULT_DIV;
        end else begin
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            txd_q      <= txd_d;
            baud_cnt_q <= baud_cnt_d;
            bit_lim_q  <= bit_lim_d;
        end
    end

    assign txd   = txd_q;
    assign txIrq = irq_en_q & fifo_empty & ~tx_busy;

    always_comb begin
        ioRdData = Zero;
        if (ioCe == RamEnable) begin
            case (reg_sel)
                RegStatus: begin
                    ioRdData[StatFullBit]            = fifo_full;
                    ioRdData[StatEmptyBit]           = fifo_empty;
                    ioRdData[StatBusyBit]            = tx_busy;
                    ioRdData[StatOvfBit]             = ovf_q;
                    ioRdData[StatCountLsb +: 4]      = 4'(fifo_count);
                end
                RegBaudDiv: ioRdData[15:0] = baud_div_q;
                RegCtrl: begin
                    ioRdData[CtrlTxEnBit]  = tx_en_q;
                    ioRdData[CtrlIrqEnBit] = irq_en_q;
                end
                default: ioRdData = Zero;
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: register-access vector table plus hand-written
// multi-cycle sequences for framing, FIFO overflow, clear, interrupt and async reset.
module tb_io_uart_tx;

    localparam logic [31:0] ATx = 32'h7000_0000;
    localparam logic [31:0] ASt = 32'h7000_0004;
    localparam logic [31:0] ABd = 32'h7000_0008;
    localparam logic [31:0] ACt = 32'h7000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        ioCe, ioWe;
    logic [31:0] ioAddr, ioWtData, ioRdData;
    logic        txd, txIrq;

    int errors = 0;
    int checks = 0;

    logic        s_txd, s_irq;
    logic [31:0] s_rd;

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [19];

    always #5 clk = ~clk;

    io_uart_tx #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ioCe     (ioCe),
        .ioWe     (ioWe),
        .ioAddr   (ioAddr),
        .ioWtData (ioWtData),
        .ioRdData (ioRdData),
        .txd      (txd),
        .txIrq    (txIrq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, hold through the rising edge.
    task automatic cyc(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd);
        @(negedge clk);
        ioCe = ce; ioWe = we; ioAddr = addr; ioWtData = wd;
        #1;
        s_txd = txd; s_irq = txIrq; s_rd = ioRdData;
        @(posedge clk);
        #1;
        ioCe = 1'b0; ioWe = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        cyc(1'b1, 1'b1, addr, wd);
    endtask

    task automatic st();
        cyc(1'b1, 1'b0, ASt, 32'h0);
    endtask

    // Slot 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ioCe = 1'b0; ioWe = 1'b0; ioAddr = '0; ioWtData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset txd", {31'b0, txd}, 32'h1);
        check("reset txIrq", {31'b0, txIrq}, 32'h0);

        vecs[0]  = '{1'b1, 1'b0, ASt, 32'h0,         32'h0000_0002};
        vecs[1]  = '{1'b1, 1'b0, ABd, 32'h0,         32'd868};
        vecs[2]  = '{1'b1, 1'b0, ACt, 32'h0,         32'h0};
        vecs[3]  = '{1'b1, 1'b0, ATx, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 1'b1, ABd, 32'h0000_1234, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, ABd, 32'h0,         32'h0000_1234};
        vecs[6]  = '{1'b1, 1'b1, ABd, 32'hABCD_0005, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, ABd, 32'h0,         32'h5};
        vecs[8]  = '{1'b1, 1'b1, ABd, 32'h0,         32'h0};
        vecs[9]  = '{1'b1, 1'b0, ABd, 32'h0,         32'h1};
        vecs[10] = '{1'b0, 1'b1, ABd, 32'h7,         32'h0};
        vecs[11] = '{1'b0, 1'b0, ABd, 32'h0,         32'h0};
        vecs[12] = '{1'b1, 1'b0, ABd, 32'h0,         32'h1};
        vecs[13] = '{1'b1, 1'b1, ACt, 32'hF,         32'h0};
        vecs[14] = '{1'b1, 1'b0, ACt, 32'h0,         32'h5};
        vecs[15] = '{1'b1, 1'b1, ACt, 32'h0,         32'h0};
        vecs[16] = '{1'b1, 1'b0, ACt, 32'h0,         32'h0};
        vecs[17] = '{1'b1, 1'b1, ASt, 32'hFFFF,      32'h0};
        vecs[18] = '{1'b1, 1'b0, ASt, 32'h0,         32'h0000_0002};

        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].wd);
            if (!vecs[i].we) check($sformatf("vec%0d read", i), s_rd, vecs[i].exp);
        end

        // Single 0x55 frame at divisor 4.
        wr(ABd, 32'd4);
        wr(ACt, 32'h1);
        wr(ATx, 32'h55);
        st();
        check("A pre txd", {31'b0, s_txd}, 32'h1);
        check("A pre status", s_rd, 32'h0000_0100);
        for (int k = 1; k <= 40; k++) begin
            st();
            check($sformatf("A txd k=%0d", k), {31'b0, s_txd},
                  {31'b0, exp_bit(8'h55, (k - 1) / 4)});
            check($sformatf("A status k=%0d", k), s_rd, 32'h0000_0006);
        end
        st();
        check("A idle txd", {31'b0, s_txd}, 32'h1);
        check("A idle status", s_rd, 32'h0000_0002);

        // Fill, overflow, then eight back-to-back frames at divisor 2.
        wr(ACt, 32'h0);
        wr(ABd, 32'd2);
        for (int i = 1; i <= 8; i++) wr(ATx, 32'(i));
        st();
        check("B full status", s_rd, 32'h0000_0801);
        wr(ATx, 32'h09);
        st();
        check("B overflow status", s_rd, 32'h0000_0809);
        wr(ACt, 32'h1);
        st();
        check("B pre txd", {31'b0, s_txd}, 32'h1);
        for (int c = 1; c <= 160; c++) begin
            st();
            check($sformatf("B txd c=%0d", c), {31'b0, s_txd},
                  {31'b0, exp_bit(8'((c - 1) / 20 + 1), ((c - 1) % 20) / 2)});
            if (c == 1) check("B first pop status", s_rd, 32'h0000_070C);
        end
        st();
        check("B end txd", {31'b0, s_txd}, 32'h1);
        check("B end status", s_rd, 32'h0000_000A);
        wr(ACt, 32'h9);
        st();
        check("B ovf cleared", s_rd, 32'h0000_0002);

        // FIFO clear mid-frame: current frame finishes, queued bytes dropped.
        wr(ACt, 32'h0);
        wr(ABd, 32'd4);
        wr(ATx, 32'hA1);
        wr(ATx, 32'hB2);
        wr(ATx, 32'hC3);
        st();
        check("C queued status", s_rd, 32'h0000_0300);
        wr(ACt, 32'h1);
        for (int c = 0; c <= 45; c++) begin
            if (c == 10) wr(ACt, 32'h3);
            else         st();
            check($sformatf("C txd c=%0d", c), {31'b0, s_txd},
                  {31'b0, (c == 0) ? 1'b1 : exp_bit(8'hA1, (c - 1) / 4)});
            if (c == 11) check("C cleared status", s_rd, 32'h0000_0006);
            if (c == 40) check("C stop status", s_rd, 32'h0000_0006);
            if (c == 41) check("C idle status", s_rd, 32'h0000_0002);
            if (c == 45) check("C still idle", s_rd, 32'h0000_0002);
        end

        // Interrupt follows empty & idle.
        wr(ACt, 32'h5);
        st();
        check("D irq idle", {31'b0, s_irq}, 32'h1);
        wr(ATx, 32'h3C);
        st();
        check("D irq queued", {31'b0, s_irq}, 32'h0);
        for (int k = 1; k <= 40; k++) begin
            st();
            check($sformatf("D txd k=%0d", k), {31'b0, s_txd},
                  {31'b0, exp_bit(8'h3C, (k - 1) / 4)});
            check($sformatf("D irq k=%0d", k), {31'b0, s_irq}, 32'h0);
        end
        st();
        check("D irq after stop", {31'b0, s_irq}, 32'h1);
        wr(ABd, 32'h0);
        cyc(1'b1, 1'b0, ABd, 32'h0);
        check("D bauddiv zero", s_rd, 32'h1);

        // Asynchronous reset during the DATA state.
        wr(ABd, 32'd4);
        wr(ATx, 32'h00);
        wr(ATx, 32'h7E);
        for (int j = 1; j <= 12; j++) begin
            st();
            check($sformatf("E txd j=%0d", j), {31'b0, s_txd},
                  {31'b0, exp_bit(8'h00, (j - 1) / 4)});
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        ioCe = 1'b1; ioWe = 1'b0; ioAddr = ASt;
        #1;
        check("E async txd", {31'b0, txd}, 32'h1);
        check("E async status", ioRdData, 32'h0000_0002);
        check("E async irq", {31'b0, txIrq}, 32'h0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            #1;
            check($sformatf("E hold txd %0d", j), {31'b0, txd}, 32'h1);
            check($sformatf("E hold status %0d", j), ioRdData, 32'h0000_0002);
        end
        @(negedge clk);
        rst = 1'b1;
        ioCe = 1'b0;
        cyc(1'b1, 1'b0, ABd, 32'h0);
        check("E bauddiv after reset", s_rd, 32'd868);
        cyc(1'b1, 1'b0, ACt, 32'h0);
        check("E ctrl after reset", s_rd, 32'h0);
        wr(ACt, 32'h1);
        for (int j = 0; j < 10; j++) begin
            st();
            check($sformatf("E no frame txd %0d", j), {31'b0, s_txd}, 32'h1);
            check($sformatf("E no frame status %0d", j), s_rd, 32'h0000_0002);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
